// File: rtl/arb_2x1_pkg.sv
// -----------------------------------------------------------------------------
// arb_2x1_pkg
// Definitions shared by the two-input round-robin stream arbiter and the
// downstream 2x1 mux select path.
//   SRC_A / SRC_B : select encoding (1 = source a, 0 = source b)
//   DEF_WIDTH     : default payload width
//   DEF_CNT_W     : default delivered-beat counter width
//   out_state_e   : output register occupancy (EMPTY / FULL)
// -----------------------------------------------------------------------------
package arb_2x1_pkg;

  localparam logic SRC_A     = 1'b1;
  localparam logic SRC_B     = 1'b0;
  localparam int   DEF_WIDTH = 8;
  localparam int   DEF_CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/arb_2x1_if.sv
// -----------------------------------------------------------------------------
// arb_2x1_if
// Stream bundle around the arbiter: two source streams (a, b), one output
// stream (c) with its select, and the delivered-beat counter.
//
// Handshake: on every stream a beat moves when valid && ready are both high at
// a rising clk edge. valid/data come from the producer, ready from the
// consumer; a producer holds valid/data until the beat is taken.
//
// Modports:
//   master : the arbiter (consumes a/b, produces c, sel, beat_cnt)
//   slave  : the surrounding logic (produces a/b, consumes c)
// -----------------------------------------------------------------------------
interface arb_2x1_if
  import arb_2x1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] c_data;
  logic             c_valid;
  logic             c_ready;
  logic             sel;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    input  a_data, a_valid, b_data, b_valid, c_ready,
    output a_ready, b_ready, c_data, c_valid, sel, beat_cnt
  );

  modport slave (
    output a_data, a_valid, b_data, b_valid, c_ready,
    input  a_ready, b_ready, c_data, c_valid, sel, beat_cnt
  );

endinterface

// File: rtl/arb_2x1_rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Combinational two-way round-robin grant.
//   i_req  [1:0] : request vector, bit SRC_A = source a, bit SRC_B = source b
//   i_last       : 1 when source a won the previous grant
//   o_gnt  [1:0] : one-hot grant, or zero when nothing requests
// -----------------------------------------------------------------------------
module rr_grant2
  import arb_2x1_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[SRC_A] && i_req[SRC_B]) begin
      // Tie: the source that did not win last time goes now.
      if (i_last == SRC_A) o_gnt[SRC_B] = 1'b1;
      else                 o_gnt[SRC_A] = 1'b1;
    end else if (i_req[SRC_A]) begin
      o_gnt[SRC_A] = 1'b1;
    end else if (i_req[SRC_B]) begin
      o_gnt[SRC_B] = 1'b1;
    end
  end

endmodule

// File: rtl/arb_2x1.sv
// -----------------------------------------------------------------------------
// arb_2x1
// Two-input round-robin stream arbiter with a registered output stage.
// One beat per cycle is granted from source a or b and registered onto c with
// sel identifying the winner (1 = a, 0 = b).
//   clk         : rising-edge clock
//   rst         : asynchronous, active-high reset
//   bus         : arb_2x1_if.master (a/b sources, c output, sel, beat_cnt)
//   o_dbg_state : output register occupancy (EMPTY / FULL)
// -----------------------------------------------------------------------------
module arb_2x1
  import arb_2x1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
)(
  input  logic        clk,
  input  logic        rst,
  arb_2x1_if.master   bus,
  output out_state_e  o_dbg_state
);

  out_state_e       r_state;
  out_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_c_data;
  logic             r_sel;
  logic             r_rr_last;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_load;
  logic             w_any_gnt;
  logic             w_c_valid;
  logic             w_c_xfer;

  assign w_c_valid = (r_state == ST_FULL);

  // The output register can take a beat when it is empty or being drained.
  // Held low during reset so no source sees ready while the block is cleared.
  assign w_load = !rst && (!w_c_valid || bus.c_ready);

  assign w_req[SRC_A] = bus.a_valid;
  assign w_req[SRC_B] = bus.b_valid;

  rr_grant2 u_rr_grant2 (
    .i_req  (w_req),
    .i_last (r_rr_last),
    .o_gnt  (w_gnt)
  );

  assign w_any_gnt = |w_gnt;
  assign w_c_xfer  = w_c_valid && bus.c_ready;

  // Output stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Next state: a loading cycle either refills (grant) or empties (no grant);
  // a stalled cycle holds.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      if (w_any_gnt) w_state_nxt = ST_FULL;
      else           w_state_nxt = ST_EMPTY;
    end
  end

  // Payload, select and round-robin pointer change only when a beat is loaded;
  // an empty load leaves them holding their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_data  <= '0;
      r_sel     <= SRC_B;
      r_rr_last <= SRC_B;
    end else if (w_load && w_any_gnt) begin
      r_c_data  <= w_gnt[SRC_A] ? bus.a_data : bus.b_data;
      r_sel     <= w_gnt[SRC_A];
      r_rr_last <= w_gnt[SRC_A];
    end
  end

  // Delivered-beat counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_beat_cnt <= '0;
    else if (w_c_xfer) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
  end

  assign bus.a_ready  = w_load && w_gnt[SRC_A];
  assign bus.b_ready  = w_load && w_gnt[SRC_B];
  assign bus.c_data   = r_c_data;
  assign bus.c_valid  = w_c_valid;
  assign bus.sel      = r_sel;
  assign bus.beat_cnt = r_beat_cnt;
  assign o_dbg_state  = r_state;

endmodule
